// File: rtl/step_ram_if.sv
// Bus bundle for step_ram: write strobe, four-phase read handshake
// and the busy flag reported during the post-reset clear sweep.
interface step_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  write;
  logic [ADDR_WIDTH-1:0] WriteAddr;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  read;
  logic [ADDR_WIDTH-1:0] ReadAddr;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  ReadReady;
  logic                  Busy;

  modport master (
    output write, WriteAddr, WriteData,
    output read, ReadAddr,
    input  ReadData, ReadReady, Busy
  );

  modport slave (
    input  write, WriteAddr, WriteData,
    input  read, ReadAddr,
    output ReadData, ReadReady, Busy
  );
endinterface

// File: rtl/step_ram.sv
// Step memory for button patterns: single-cycle writes, four-phase
// reads, and a zeroing sweep after every reset.
module step_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input logic       clk,
  input logic       reset,
  step_ram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    FETCH,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  fwd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // Sweep owns the array while clearing; user writes are dropped then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR)
        mem[cnt_q] <= '0;
      else if (bus.write)
        mem[bus.WriteAddr] <= bus.WriteData;
    end
  end

  assign fwd = bus.write && (bus.WriteAddr == addr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1)
          state_d = IDLE;
      end
      IDLE: begin
        if (bus.read) begin
          addr_d  = bus.ReadAddr;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rdata_d = fwd ? bus.WriteData : mem[addr_q];
        state_d = DONE;
      end
      DONE: begin
        if (!bus.read)
          state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    bus.ReadData  = rdata_q;
    bus.ReadReady = (state_q == DONE);
    bus.Busy      = (state_q == CLEAR);
  end
endmodule

// File: tb/tb_step_ram.sv
// Directed bench for step_ram: clear sweep, read/write timing,
// FETCH forwarding and reset abort.
module tb_step_ram;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   checks = 0;

  step_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

  step_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.write     = 1'b1;
    bus.WriteAddr = a;
    bus.WriteData = d;
    step();
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp);
    bus.ReadAddr = a;
    bus.read     = 1'b1;
    step();
    chk("rd_lat1", 32'(bus.ReadReady), 32'd0);
    step();
    chk("rd_rdy", 32'(bus.ReadReady), 32'd1);
    chk("rd_data", 32'(bus.ReadData), 32'(exp));
    bus.read = 1'b0;
    step();
    chk("rd_drop", 32'(bus.ReadReady), 32'd0);
  endtask

  task automatic sweep();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("busy_sweep", 32'(bus.Busy), 32'd1);
    end
    step();
    chk("busy_end", 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    bus.write     = 1'b0;
    bus.WriteAddr = '0;
    bus.WriteData = '0;
    bus.read      = 1'b0;
    bus.ReadAddr  = '0;

    step();
    step();
    chk("rst_rdy", 32'(bus.ReadReady), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd1);
    chk("rst_data", 32'(bus.ReadData), 32'd0);
    reset = 1'b0;
    sweep();
    for (int a = 0; a < 4; a++)
      rd(2'(a), 8'h00);

    wr(2'd0, 8'h01);
    wr(2'd1, 8'h02);
    wr(2'd2, 8'h03);
    wr(2'd3, 8'h00);
    rd(2'd0, 8'h01);
    rd(2'd1, 8'h02);
    rd(2'd2, 8'h03);
    rd(2'd3, 8'h00);

    // read held for 6 cycles on addr1; address change after capture ignored
    bus.ReadAddr = 2'd1;
    bus.read     = 1'b1;
    step();
    bus.ReadAddr = 2'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rdy", 32'(bus.ReadReady), 32'd1);
      chk("hold_data", 32'(bus.ReadData), 32'h02);
    end
    bus.read = 1'b0;
    step();
    chk("hold_drop", 32'(bus.ReadReady), 32'd0);
    chk("hold_keep", 32'(bus.ReadData), 32'h02);

    // write forwarded during FETCH, ignored by held data in DONE
    bus.ReadAddr = 2'd2;
    bus.read     = 1'b1;
    step();
    wr(2'd2, 8'hA5);
    chk("fwd_rdy", 32'(bus.ReadReady), 32'd1);
    chk("fwd_data", 32'(bus.ReadData), 32'hA5);
    wr(2'd2, 8'h5A);
    chk("done_hold", 32'(bus.ReadData), 32'hA5);
    bus.read = 1'b0;
    step();
    rd(2'd2, 8'h5A);

    // reset while ReadReady is high, write during CLEAR dropped
    bus.ReadAddr = 2'd1;
    bus.read     = 1'b1;
    step();
    step();
    chk("pre_rst_rdy", 32'(bus.ReadReady), 32'd1);
    bus.read = 1'b0;
    reset    = 1'b1;
    step();
    chk("abort_rdy", 32'(bus.ReadReady), 32'd0);
    chk("abort_busy", 32'(bus.Busy), 32'd1);
    chk("abort_data", 32'(bus.ReadData), 32'd0);
    reset         = 1'b0;
    bus.write     = 1'b1;
    bus.WriteAddr = 2'd0;
    bus.WriteData = 8'h77;
    sweep();
    bus.write = 1'b0;
    for (int a = 0; a < 4; a++)
      rd(2'(a), 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/step_ram.md
# step_ram

Small synchronous step memory that sits directly downstream of the button sequencer. It stores the 2-bit button patterns the sequencer captures and returns them on request for LED playback. Writes are single-cycle strobes; reads use a four-phase `read`/`ReadReady` handshake. After reset, a clear sweep zeroes every entry before the memory accepts traffic.

## Interface
- `DATA_WIDTH`, 8: width of each stored word.
- `ADDR_WIDTH`, 2: address width. Depth is `DEPTH = 2**ADDR_WIDTH`, so 4 entries by default.

- `clk` input 1: system clock. Everything is registered on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `write` input 1: write strobe, sampled each edge.
- `WriteAddr` input ADDR_WIDTH: write address.
- `WriteData` input DATA_WIDTH: write data.
- `read` input 1: read request level (four-phase handshake).
- `ReadAddr` input ADDR_WIDTH: read address, captured when a request is accepted.
- `ReadData` output DATA_WIDTH: registered read data, stable while `ReadReady`=1.
- `ReadReady` output 1: read data valid; held until `read` drops.
- `Busy` output 1: high during reset and the clear sweep; all traffic is ignored while high.

## Operation
- States: CLEAR, IDLE, FETCH, DONE.
- Reset, any edge with `reset`=1:
  - state=CLEAR, clear counter=0.
  - `ReadData`=0, `ReadReady`=0, `Busy`=1.
  - Memory contents are not touched on that edge.
- CLEAR:
  - Each edge writes 0 to `mem[counter]` and increments the counter.
  - After writing entry DEPTH-1, go to IDLE and set `Busy`=0.
  - `write` is dropped. `read` is not accepted, but because it is a level it is serviced once IDLE is reached.
- IDLE: with `read`=1, capture `ReadAddr` into an internal address register and go to FETCH.
- FETCH:
  - Load `ReadData` from `mem[captured addr]`, set `ReadReady`=1, go to DONE.
  - Changes on `ReadAddr` after capture have no effect.
- DONE:
  - Hold `ReadData` and `ReadReady`=1 while `read`=1.
  - When `read`=0, clear `ReadReady` and return to IDLE. `ReadData` keeps its last value.
- Writes:
  - Any edge outside CLEAR/reset with `write`=1 commits `mem[WriteAddr] <= WriteData`, independent of the read state.
  - A multi-cycle `write` rewrites the entry every cycle (idempotent).
- Collision: a write in the same cycle as FETCH to the captured address is forwarded, so `ReadData` gets the new `WriteData`.
- A write to the captured address while in DONE does not update the held `ReadData`.
- Addresses wrap naturally at ADDR_WIDTH bits. Out-of-range addresses cannot occur.

## Timing
- Reset asserted at edge N: `ReadReady`=0, `Busy`=1, `ReadData`=0 after edge N.
- Reset deasserted before edge M: CLEAR runs edges M..M+DEPTH-1. `Busy` falls after edge M+DEPTH-1 (DEPTH cycles, 4 by default).
- Read latency: `read` high at edge k in IDLE gives FETCH after k. `ReadReady`=1 with valid data after edge k+1, i.e. 2 cycles.
- `read` dropping at edge j while in DONE: `ReadReady`=0 after j. A new request is accepted at edge j+1 at the earliest.
- Write latency: data is committed at the strobe edge and is readable by a request accepted on the next edge.
- Reset mid-read or mid-CLEAR: the operation is aborted, `ReadReady` is cleared at that edge, and the sweep restarts from entry 0.

## Test plan
- Reset for 2 cycles, then release. Expect `Busy`=1 for exactly 4 cycles, then 0. Reads of addresses 0..3 all return 0x00.
- Write 0x01→addr0, 0x02→addr1, 0x03→addr2, 0x00→addr3 with 1-cycle strobes, then read each address. Expect `ReadReady` 2 cycles after `read` rises and `ReadData` = written values.
- Hold `read`=1 for 6 cycles on addr1. Expect `ReadReady` to stay 1 and `ReadData`=0x02 throughout. `ReadReady` falls 1 cycle after `read` drops.
- Issue a read of addr2 with a same-cycle write of 0xA5 to addr2 during FETCH. Expect `ReadData`=0xA5. A later write in DONE leaves `ReadData` unchanged.
- Assert `reset` while `ReadReady`=1. Expect `ReadReady`=0 and `Busy`=1 on the next edge. After the sweep, all entries read 0x00. A `write` during CLEAR is not stored.
